// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared types and constants for the bit-serial adder.
//               state_t - controller states IDLE / RUN / DONE
//               SERIAL_ADDER_WIDTH_DEFAULT - default operand width
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam int SERIAL_ADDER_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_fa.sv
`default_nettype none
// ============================================================================
// Module      : fa
// Description : One-bit full adder used by the serial adder datapath.
// Ports       : x, y  - addend bits
//               ci    - carry in
//               s     - sum bit
//               co    - carry out
// Revision    : 1.0 - initial release
// ============================================================================
module fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule : fa
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder. An accepted start captures a, b and cin,
//               then one operand bit pair is added per clock (LSB first) for
//               WIDTH cycles, after which done pulses for one cycle and the
//               sum / carry-out are held until the next accepted start.
// Ports       : clk   - clock, rising edge
//               rst   - synchronous active-high reset
//               start - begin an addition (sampled only in IDLE)
//               a, b  - WIDTH-bit operands
//               cin   - carry in
//               busy  - high while in RUN
//               done  - one-cycle result-valid pulse
//               s     - WIDTH-bit sum
//               c     - carry out
//               ovf   - signed overflow (only with SERIAL_ADDER_OVF_EN)
// Config      : `define SERIAL_ADDER_OVF_EN to add the ovf output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_sum;
    logic             w_co;
    logic             w_last;

    fa u_fa (
        .x  (r_a[0]),
        .y  (r_b[0]),
        .ci (r_carry),
        .s  (w_sum),
        .co (w_co)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: sum bits enter at the MSB so that after WIDTH shifts the
    // first (LSB) sum bit has walked down to bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_s     <= {w_sum, r_s[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign s = r_s;
    assign c = r_carry;

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the last RUN edge r_carry is the carry into the MSB and w_co the
    // carry out of it; their XOR is the two's-complement overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= r_carry ^ w_co;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed self-checking bench for serial_adder (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int n_checks;
    int n_fail;
    int cyc;
    int last_done_cyc;

    serial_adder #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .c     (c)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count done pulses over a window of n cycles.
    task automatic count_done(input int n, output int nd);
        nd = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) nd++;
        end
    endtask

    // Run one addition. poke=1 pulses start (with other operands) during RUN
    // and during DONE; those must be ignored.
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic icin, input logic [7:0] es, input logic ec,
                          input logic eovf, input bit poke);
        int n;
        int nbusy;
        int nd;
        start = 1'b1; a = ia; b = ib; cin = icin;
        tick();
        start = 1'b0;
        a = ~ia; b = ~ib; cin = ~icin;   // late operand changes must not matter
        n = 0;
        nbusy = 0;
        while (!done && n < 20) begin
            if (busy) nbusy++;
            if (poke) start = (n == 3);
            tick();
            n++;
        end
        start = 1'b0;
        last_done_cyc = cyc;
        check({tag, "_latency"}, n, 8);
        check({tag, "_busy_cycles"}, nbusy, 8);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 0);
        check({tag, "_s"}, {24'd0, s}, {24'd0, es});
        check({tag, "_c"}, {31'd0, c}, {31'd0, ec});
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
`else
        if (eovf === 1'bx) n_fail++;   // keep argument referenced
`endif
        if (poke) begin
            start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
            tick();
            start = 1'b0;
            check({tag, "_idle_after_done"}, {31'd0, busy}, 0);
            count_done(12, nd);
            check({tag, "_no_extra_done"}, nd, 0);
            check({tag, "_s_intact"}, {24'd0, s}, {24'd0, es});
            check({tag, "_c_intact"}, {31'd0, c}, {31'd0, ec});
        end
    endtask

    initial begin
        int nd;
        int first_done;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_s", {24'd0, s}, 0);
        check("rst_c", {31'd0, c}, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 0);
`endif
        tick();
        check("idle_no_start_busy", {31'd0, busy}, 0);

        run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
        tick();
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        check("idle_hold_s", {24'd0, s}, 0);
        check("idle_hold_c", {31'd0, c}, 1);
        run_op("add_7f_00_c", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
        tick();
        run_op("poke", 8'h3C, 8'h11, 1'b1, 8'h4E, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of RUN
        start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("pre_rst_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_done", {31'd0, done}, 0);
        check("mid_rst_s", {24'd0, s}, 0);
        check("mid_rst_c", {31'd0, c}, 0);
        count_done(12, nd);
        check("mid_rst_no_done", nd, 0);
        run_op("after_rst", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);

        // Back-to-back: second start in first IDLE cycle after done
        tick();
        run_op("b2b_1", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        first_done = last_done_cyc;
        tick();
        run_op("b2b_2", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        check("b2b_spacing", last_done_cyc - first_done, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
